// File: rtl/ipf_pkg.sv
// Shared definitions for the IPF host-side sequencer: ctrl command codes,
// sequencer state encoding and default beat/window counts.
package ipf_pkg;

   typedef enum logic [2:0] {
      IPF_NOP   = 3'd0,
      IPF_START = 3'd1,
      IPF_NEXT  = 3'd2
   } ipf_ctrl_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LD_I,
      ST_LD_W,
      ST_W_TAIL,
      ST_START,
      ST_WAIT,
      ST_NEXT,
      ST_DONE
   } ipf_state_e;

   localparam int unsigned IPF_I_BEATS_DEF     = 8;
   localparam int unsigned IPF_W_BEATS_DEF     = 4;
   localparam int unsigned IPF_W_SETS_DEF      = 7;
   localparam int unsigned IPF_W_GROUPS_DEF    = 2;
   localparam int unsigned IPF_COMPUTE_CYC_DEF = 32;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned ipf_cw(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ipf_seq_fetch.sv
// Burst address generator for one memory stream: issues base+beat while
// enabled and presents a valid flag delayed to match the one-cycle read latency.
module ipf_seq_fetch
   import ipf_pkg::*;
#(
   parameter int unsigned BEATS = IPF_I_BEATS_DEF,
   parameter int unsigned AW    = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en_i,
   input  logic [AW-1:0] base_i,
   output logic [AW-1:0] addr_o,
   output logic          last_o,
   output logic          valid_o
);

   localparam int unsigned BW = ipf_cw(BEATS);

   logic [BW-1:0] beat_q;
   logic          valid_q;

   assign last_o  = (beat_q == BW'(BEATS - 1));
   assign addr_o  = base_i + AW'(beat_q);
   assign valid_o = valid_q;

   // Dropping en_i mid-burst rewinds the beat so the next burst starts at base.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         beat_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         valid_q <= en_i;
         if (en_i && !last_o) beat_q <= beat_q + 1'b1;
         else                 beat_q <= '0;
      end
   end

endmodule

// File: rtl/ipf_seq.sv
// IPF host-side sequencer: streams image tiles and weight sets into IPF and
// paces START/NEXT commands. Optional watchdog enabled by IPF_SEQ_TIMEOUT_EN.
module ipf_seq
   import ipf_pkg::*;
#(
   parameter int unsigned DATA_W      = 64,
   parameter int unsigned I_BEATS     = IPF_I_BEATS_DEF,
   parameter int unsigned W_BEATS     = IPF_W_BEATS_DEF,
   parameter int unsigned W_SETS      = IPF_W_SETS_DEF,
   parameter int unsigned W_GROUPS    = IPF_W_GROUPS_DEF,
   parameter int unsigned COMPUTE_CYC = IPF_COMPUTE_CYC_DEF,
   parameter int unsigned IA_W        = 16,
   parameter int unsigned WA_W        = 8,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TIMEOUT     = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_tiles,
   output logic [IA_W-1:0]   i_addr,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [WA_W-1:0]   w_addr,
   input  logic [DATA_W-1:0] w_rdata,
   output logic [2:0]        ctrl,
   output logic              i_valid,
   output logic [DATA_W-1:0] i_data,
   output logic              w_valid,
   output logic [DATA_W-1:0] w_data,
   input  logic              res_valid,
   input  logic              finish,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  res_cnt,
   output logic              timeout_err
);

   localparam int unsigned SW = ipf_cw(W_SETS);
   localparam int unsigned GW = ipf_cw(W_GROUPS);
   localparam int unsigned CW = ipf_cw(COMPUTE_CYC);

   ipf_state_e       state_q;
   ipf_ctrl_e        ctrl_q;
   logic             busy_q;
   logic             done_q;
   logic [CNT_W-1:0] tile_q;
   logic [CNT_W-1:0] ntiles_q;
   logic [CNT_W-1:0] res_cnt_q;
   logic [GW-1:0]    group_q;
   logic [SW-1:0]    set_q;
   logic [CW-1:0]    wait_q;

   logic             i_last;
   logic             w_last;
   logic             wd_hit;
   logic             abort;
   logic [IA_W-1:0]  i_base;
   logic [WA_W-1:0]  w_base;

   assign i_base = IA_W'(tile_q * I_BEATS);
   assign w_base = WA_W'(set_q * W_BEATS);

   ipf_seq_fetch #(
      .BEATS (I_BEATS),
      .AW    (IA_W)
   ) u_fetch_i (
      .clk     (clk),
      .rst     (rst),
      .en_i    (state_q == ST_LD_I),
      .base_i  (i_base),
      .addr_o  (i_addr),
      .last_o  (i_last),
      .valid_o (i_valid)
   );

   ipf_seq_fetch #(
      .BEATS (W_BEATS),
      .AW    (WA_W)
   ) u_fetch_w (
      .clk     (clk),
      .rst     (rst),
      .en_i    (state_q == ST_LD_W),
      .base_i  (w_base),
      .addr_o  (w_addr),
      .last_o  (w_last),
      .valid_o (w_valid)
   );

   // An early stop is honoured anywhere in a run except the DONE cycle itself.
   assign abort = ((state_q != ST_IDLE) && (state_q != ST_DONE) && finish) || wd_hit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ctrl_q    <= IPF_NOP;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tile_q    <= '0;
         ntiles_q  <= '0;
         res_cnt_q <= '0;
         group_q   <= '0;
         set_q     <= '0;
         wait_q    <= '0;
      end else begin
         ctrl_q <= IPF_NOP;
         done_q <= 1'b0;
         if (res_valid && busy_q && (res_cnt_q != '1)) res_cnt_q <= res_cnt_q + 1'b1;

         if (abort) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (start) begin
                     ntiles_q  <= num_tiles;
                     res_cnt_q <= '0;
                     tile_q    <= '0;
                     group_q   <= '0;
                     busy_q    <= 1'b1;
                     if (num_tiles == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= ST_LD_I;
                     end
                  end
               end
               ST_LD_I: begin
                  if (i_last) state_q <= ST_LD_W;
               end
               ST_LD_W: begin
                  if (w_last) begin
                     set_q   <= (set_q == SW'(W_SETS - 1)) ? '0 : set_q + 1'b1;
                     state_q <= ST_W_TAIL;
                  end
               end
               ST_W_TAIL: begin
                  state_q <= ST_START;
                  ctrl_q  <= IPF_START;
               end
               ST_START: begin
                  state_q <= ST_WAIT;
                  wait_q  <= '0;
               end
               ST_WAIT: begin
                  if (wait_q == CW'(COMPUTE_CYC - 1)) begin
                     state_q <= ST_NEXT;
                     ctrl_q  <= IPF_NEXT;
                  end else begin
                     wait_q <= wait_q + 1'b1;
                  end
               end
               ST_NEXT: begin
                  if (group_q != GW'(W_GROUPS - 1)) begin
                     group_q <= group_q + 1'b1;
                     state_q <= ST_LD_W;
                  end else if (tile_q != (ntiles_q - 1'b1)) begin
                     tile_q  <= tile_q + 1'b1;
                     group_q <= '0;
                     state_q <= ST_LD_I;
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
               end
               ST_DONE: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
               default: state_q <= ST_IDLE;
            endcase
         end
      end
   end

`ifdef IPF_SEQ_TIMEOUT_EN
   localparam int unsigned WDW = ipf_cw(TIMEOUT);

   logic [WDW-1:0] wd_q;
   logic           wd_arm_q;
   logic           timeout_err_q;

   assign wd_hit = wd_arm_q && (wd_q == WDW'(TIMEOUT - 1)) &&
                   (state_q != ST_IDLE) && (state_q != ST_DONE);

   // Armed by the first START of a run; every res_valid restarts the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_q          <= '0;
         wd_arm_q      <= 1'b0;
         timeout_err_q <= 1'b0;
      end else if (state_q == ST_IDLE) begin
         wd_q     <= '0;
         wd_arm_q <= 1'b0;
         if (start) timeout_err_q <= 1'b0;
      end else begin
         if (wd_hit) begin
            timeout_err_q <= 1'b1;
            wd_arm_q      <= 1'b0;
         end else if (state_q == ST_START) begin
            wd_arm_q <= 1'b1;
         end
         if (res_valid || !wd_arm_q) wd_q <= '0;
         else                        wd_q <= wd_q + 1'b1;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   logic wd_unused;
   assign wd_unused   = (TIMEOUT == 0);
   assign wd_hit      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign ctrl    = ctrl_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign res_cnt = res_cnt_q;
   assign i_data  = i_rdata;
   assign w_data  = w_rdata;

endmodule

// File: tb/tb_ipf_seq.sv
// Self-checking bench for ipf_seq: schedule-based reference model plus
// directed literal pins and a randomized run phase.
module tb_ipf_seq;

   localparam int MAXC = 8192;
`ifdef IPF_SEQ_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 100;
`else
   localparam int unsigned TB_TIMEOUT = 1024;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_tiles;
   logic [15:0] i_addr;
   logic [63:0] i_rdata;
   logic [7:0]  w_addr;
   logic [63:0] w_rdata;
   logic [2:0]  ctrl;
   logic        i_valid;
   logic [63:0] i_data;
   logic        w_valid;
   logic [63:0] w_data;
   logic        res_valid;
   logic        finish;
   logic        busy;
   logic        done;
   logic [15:0] res_cnt;
   logic        timeout_err;

   ipf_seq #(
      .DATA_W(64), .I_BEATS(8), .W_BEATS(4), .W_SETS(7), .W_GROUPS(2),
      .COMPUTE_CYC(32), .IA_W(16), .WA_W(8), .CNT_W(16), .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .num_tiles(num_tiles),
      .i_addr(i_addr), .i_rdata(i_rdata), .w_addr(w_addr), .w_rdata(w_rdata),
      .ctrl(ctrl), .i_valid(i_valid), .i_data(i_data), .w_valid(w_valid),
      .w_data(w_data), .res_valid(res_valid), .finish(finish), .busy(busy),
      .done(done), .res_cnt(res_cnt), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Memories hold word == address, one-cycle read latency.
   always @(posedge clk) begin
      i_rdata <= 64'(i_addr);
      w_rdata <= 64'(w_addr);
   end

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: per-cycle expected outputs laid out from the run rules.
   int          m_ctrl [MAXC];
   bit          m_iv   [MAXC];
   bit          m_wv   [MAXC];
   logic [63:0] m_id   [MAXC];
   logic [63:0] m_wd   [MAXC];
   bit          m_done [MAXC];
   bit          m_busy [MAXC];
   int          m_set = 0;
   int          m_set_run0 = 0;
   int          m_last_w[$];
   int          m_res = 0;
   int          m_end = 0;
   bit          chk_en = 1'b1;

   task automatic model_clear();
      for (int c = 0; c < MAXC; c++) begin
         m_ctrl[c] = 0; m_iv[c] = 0; m_wv[c] = 0; m_id[c] = '0;
         m_wd[c] = '0; m_done[c] = 0; m_busy[c] = 0;
      end
      m_set = 0; m_res = 0; m_end = 0;
      m_last_w.delete();
   endtask

   task automatic build(input int t0, input int nt);
      int t = t0;
      m_set_run0 = m_set;
      m_last_w.delete();
      for (int k = 0; k < nt; k++) begin
         for (int b = 0; b < 8; b++) begin
            m_iv[t+1+b] = 1; m_id[t+1+b] = 64'(k*8 + b);
         end
         t += 8;
         for (int g = 0; g < 2; g++) begin
            for (int b = 0; b < 4; b++) begin
               m_wv[t+1+b] = 1; m_wd[t+1+b] = 64'(m_set*4 + b);
            end
            m_last_w.push_back(t + 3);
            m_set = (m_set + 1) % 7;
            t += 5;
            m_ctrl[t] = 1;
            m_ctrl[t+33] = 2;
            t += 34;
         end
      end
      for (int c = t0; c <= t; c++) m_busy[c] = 1;
      m_done[t] = 1;
      m_end = t;
   endtask

   task automatic truncate(input int f);
      for (int c = f + 1; c <= m_end + 1; c++) begin
         m_ctrl[c] = 0; m_done[c] = 0; m_busy[c] = 0;
         if (c > f + 1) begin m_iv[c] = 0; m_wv[c] = 0; end
      end
      m_done[f+1] = 1;
      m_busy[f+1] = 1;
      m_set = m_set_run0;
      foreach (m_last_w[i]) if (m_last_w[i] < f) m_set = (m_set + 1) % 7;
      m_end = f + 1;
   endtask

   always @(negedge clk) begin
      if (chk_en && cyc < MAXC - 400) begin
         int c;
         c = cyc;
         chk("ctrl",        64'(ctrl),        64'(m_ctrl[c]));
         chk("i_valid",     64'(i_valid),     64'(m_iv[c]));
         chk("w_valid",     64'(w_valid),     64'(m_wv[c]));
         if (m_iv[c]) chk("i_data", i_data, m_id[c]);
         if (m_wv[c]) chk("w_data", w_data, m_wd[c]);
         chk("busy",        64'(busy),        64'(m_busy[c]));
         chk("done",        64'(done),        64'(m_done[c]));
         chk("res_cnt",     64'(res_cnt),     64'(m_res));
         chk("timeout_err", 64'(timeout_err), 64'(0));
         if (!rst) begin
            if (start && !m_busy[c]) begin
               m_res = 0;
               build(c + 1, int'(num_tiles));
            end else begin
               if (res_valid && m_busy[c] && m_res < 65535) m_res++;
               if (finish && m_busy[c] && !m_done[c]) truncate(c);
            end
         end
      end
   end

   bit rv_rand = 1'b1;

   task automatic tick();
      @(posedge clk);
      #1;
      start  = 1'b0;
      finish = 1'b0;
      if (rv_rand) res_valid = ($urandom_range(0, 3) == 0);
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
      @(negedge clk);
   endtask

   task automatic do_start(input int nt, output int s);
      tick();
      start = 1'b1;
      num_tiles = 16'(nt);
      s = cyc;
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1;
      model_clear();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int s;
      rst = 1'b1; start = 1'b0; num_tiles = '0; res_valid = 1'b0; finish = 1'b0;
      model_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",  64'(busy),  64'(0));
      chk("rst_ctrl",  64'(ctrl),  64'(0));
      chk("rst_iaddr", 64'(i_addr), 64'(0));
      #1 rst = 1'b0;

      // One tile: pinned latencies.
      do_start(1, s);
      wait_to(s + 2);  chk("t1_idata_first", i_data, 64'd0);
      wait_to(s + 9);  chk("t1_idata_last",  i_data, 64'd7);
      wait_to(s + 10); chk("t1_wdata_g0",    w_data, 64'd0);
      wait_to(s + 13); chk("t1_wdata_g0e",   w_data, 64'd3);
      wait_to(s + 14); chk("t1_ctrl_start0", 64'(ctrl), 64'd1);
      wait_to(s + 47); chk("t1_ctrl_next0",  64'(ctrl), 64'd2);
      wait_to(s + 49); chk("t1_wdata_g1",    w_data, 64'd4);
      wait_to(s + 52); chk("t1_wdata_g1e",   w_data, 64'd7);
      wait_to(s + 53); chk("t1_ctrl_start1", 64'(ctrl), 64'd1);
      wait_to(s + 86); chk("t1_ctrl_next1",  64'(ctrl), 64'd2);
      wait_to(s + 87); chk("t1_done",        64'(done), 64'd1);
      wait_to(s + 90);

      // Four tiles: weight set wraps back to addresses 0..3 on the 8th set.
      do_reset();
      do_start(4, s);
      wait_to(s + 267); chk("t4_idata_last", i_data, 64'd31);
      wait_to(s + 307); chk("t4_wrap_first", w_data, 64'd0);
      wait_to(s + 310); chk("t4_wrap_last",  w_data, 64'd3);
      wait_to(s + 345); chk("t4_done",       64'(done), 64'd1);
      wait_to(s + 350);

      // 64 results then finish mid-WAIT.
      rv_rand = 1'b0;
      res_valid = 1'b0;
      do_start(3, s);
      while (cyc < s + 70) begin
         tick();
         res_valid = (cyc >= s + 1) && (cyc <= s + 64);
         if (cyc == s + 70) finish = 1'b1;
      end
      wait_to(s + 71); chk("fin_done", 64'(done), 64'd1);
                       chk("fin_cnt",  64'(res_cnt), 64'd64);
      wait_to(s + 80); chk("fin_hold", 64'(res_cnt), 64'd64);
      rv_rand = 1'b1;

      // Zero tiles.
      do_start(0, s);
      wait_to(s + 1); chk("z_done", 64'(done), 64'd1);
      wait_to(s + 2); chk("z_idle", 64'(busy), 64'd0);
      wait_to(s + 5);

      // Reset during LD_W, then restart.
      do_start(2, s);
      while (cyc < s + 10) tick();
      #2 rst = 1'b1;
      model_clear();
      #1;
      chk("mr_busy",   64'(busy),    64'd0);
      chk("mr_ctrl",   64'(ctrl),    64'd0);
      chk("mr_wvalid", 64'(w_valid), 64'd0);
      chk("mr_ivalid", 64'(i_valid), 64'd0);
      chk("mr_waddr",  64'(w_addr),  64'd0);
      chk("mr_resct",  64'(res_cnt), 64'd0);
      tick();
      rst = 1'b0;
      do_start(1, s);
      wait_to(s + 1);  chk("mr_iaddr0", 64'(i_addr), 64'd0);
      wait_to(s + 10); chk("mr_wdata0", w_data, 64'd0);
      wait_to(s + 90);

      // Randomized runs with spurious starts and occasional early finish.
      for (int n = 0; n < 3000; n++) begin
         tick();
         if ($urandom_range(0, 24) == 0) begin
            start = 1'b1;
            num_tiles = 16'($urandom_range(0, 3));
         end
         if (m_busy[cyc] && !m_done[cyc] && $urandom_range(0, 199) == 0) finish = 1'b1;
      end
      begin
         int lim;
         lim = cyc + 1000;
         while (m_busy[cyc] && cyc < lim) tick();
         if (m_busy[cyc]) begin
            errors++;
            $display("FAIL rand_drain cyc=%0d got=busy exp=idle", cyc);
         end
      end
      wait_to(cyc + 3);

`ifdef IPF_SEQ_TIMEOUT_EN
      chk_en = 1'b0;
      rv_rand = 1'b0;
      res_valid = 1'b0;
      do_start(20, s);
      begin
         int lim;
         lim = cyc + 3000;
         while (!done && cyc < lim) tick();
         chk("wd_done",    64'(done),        64'd1);
         chk("wd_err",     64'(timeout_err), 64'd1);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout cyc=%0d got=running exp=finished", cyc);
      $fatal(1);
   end

endmodule
